pipeline_stall_ctrl: RTL

//   Hazard sequencer for the 4-stage ID/EX/MEM/WB integer pipeline with 16 architectural regs.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 26 ++
 rtl/scoreboard_slot_cmp.sv | 15 +
 rtl/pipeline_stall_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the ID/EX/MEM/WB hazard sequencer: operand-select encoding,
// the scoreboard slot type and the forwarding priority helper.
package pipeline_stall_ctrl_pkg;

    localparam int REG_W = 4;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] wr;
        logic             ld;
    } sb_slot_t;

    // hit[0]=EX, hit[1]=MEM, hit[2]=WB; the youngest producer wins
    function automatic logic [1:0] fwd_pick(input logic [2:0] hit);
        if (hit[0])      return FWD_EX;
        else if (hit[1]) return FWD_MEM;
        else if (hit[2]) return FWD_WB;
        else             return FWD_RF;
    endfunction

endpackage

// File: rtl/scoreboard_slot_cmp.sv
// Compares one in-flight write slot against one ID source register.
// Register 0 never matches when it is hard-wired to zero.
module scoreboard_slot_cmp #(
    parameter int REG_W   = 4,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic             slot_v,
    input  logic [REG_W-1:0] slot_wr,
    input  logic [REG_W-1:0] src,
    output logic             match
);

    assign match = slot_v && (slot_wr == src) && !(R0_ZERO && (src == '0));

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Hazard sequencer: scoreboard of in-flight writes (EX/MEM/WB) driving forwarding selects,
// load-use stalls, bubbles, branch flushes and saturating stall/flush counters.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int REG_W   = pipeline_stall_ctrl_pkg::REG_W,
    parameter int CNT_W   = 16,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rdReg1,
    input  logic [REG_W-1:0] id_rdReg2,
    input  logic             id_rd1_used,
    input  logic             id_rd2_used,
    input  logic [REG_W-1:0] id_wrReg,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             ex_branch_taken,
    input  logic             mem_wait,
    output logic             stall_IF_ID,
    output logic             bubble_EX,
    output logic             flush_IF_ID,
    output logic             freeze,
    output logic [1:0]       fwd_sel1,
    output logic [1:0]       fwd_sel2,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // The load flag only matters while the producer sits in EX, so MEM and WB keep v/wr only.
    sb_slot_t         ex_slot;
    logic             mem_v, wb_v;
    logic [REG_W-1:0] mem_wr, wb_wr;

    logic [2:0]       slot_v;
    logic [REG_W-1:0] slot_wr [3];
    logic [REG_W-1:0] src     [2];
    logic [2:0]       hit     [2];

    logic luse;
    logic ex_we;
    logic stall_inc;
    logic flush_inc;

    assign slot_v     = {wb_v, mem_v, ex_slot.v};
    assign slot_wr[0] = ex_slot.wr;
    assign slot_wr[1] = mem_wr;
    assign slot_wr[2] = wb_wr;
    assign src[0]     = id_rdReg1;
    assign src[1]     = id_rdReg2;

    for (genvar g_src = 0; g_src < 2; g_src++) begin : g_src_cmp
        for (genvar g_slot = 0; g_slot < 3; g_slot++) begin : g_slot_cmp
            scoreboard_slot_cmp #(
                .REG_W   (REG_W),
                .R0_ZERO (R0_ZERO)
            ) u_cmp (
                .slot_v  (slot_v[g_slot]),
                .slot_wr (slot_wr[g_slot]),
                .src     (src[g_src]),
                .match   (hit[g_src][g_slot])
            );
        end
    end

    assign fwd_sel1 = (id_valid && id_rd1_used) ? fwd_pick(hit[0]) : FWD_RF;
    assign fwd_sel2 = (id_valid && id_rd2_used) ? fwd_pick(hit[1]) : FWD_RF;

    assign luse = id_valid && ex_slot.ld &&
                  ((id_rd1_used && hit[0][0]) || (id_rd2_used && hit[1][0]));

    // Priority: memory freeze, then taken branch (its shadow is wrong-path), then load-use.
    always_comb begin
        stall_IF_ID = 1'b0;
        bubble_EX   = 1'b0;
        flush_IF_ID = 1'b0;
        freeze      = mem_wait;
        if (mem_wait) begin
            stall_IF_ID = 1'b1;
        end else if (ex_branch_taken) begin
            flush_IF_ID = 1'b1;
            bubble_EX   = 1'b1;
        end else if (luse) begin
            stall_IF_ID = 1'b1;
            bubble_EX   = 1'b1;
        end
    end

    assign stall_inc = !mem_wait && !ex_branch_taken && luse;
    assign flush_inc = !mem_wait && ex_branch_taken;

    assign ex_we = id_valid && id_we && !bubble_EX && !(R0_ZERO && (id_wrReg == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_slot <= '0;
            mem_v   <= 1'b0;
            mem_wr  <= '0;
            wb_v    <= 1'b0;
            wb_wr   <= '0;
        end else if (!mem_wait) begin
            wb_v       <= mem_v;
            wb_wr      <= mem_wr;
            mem_v      <= ex_slot.v;
            mem_wr     <= ex_slot.wr;
            ex_slot.v  <= ex_we;
            ex_slot.wr <= id_wrReg;
            ex_slot.ld <= id_is_load && ex_we;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule
